// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared select encoding, FSM states and reset values for the PWM front-end
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

    localparam pwm_state_t RST_STATE     = IDLE;
    localparam logic       RST_CFG_READY = 1'b1;

    // Select codes above the duty range depend on the channel count of the instance.
    function automatic int sel_period(input int channels);
        return channels;
    endfunction

    function automatic int sel_enable(input int channels);
        return channels + 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - PWM timebase counter with wrap compare and period tick
module pwm_timebase #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_en,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] counter_value,
    output logic             period_tick
);

    // Wrap only while counting, so a zero period does not tick in IDLE.
    assign period_tick = count_en && (counter_value == period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_value <= '0;
        end else if (!count_en || period_tick) begin
            counter_value <= '0;
        end else begin
            counter_value <= counter_value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_shadow_ctrl.sv
// rtl/pwm_shadow_ctrl.sv - PWM sequencer with shadowed period/duty/enable loaded at period boundaries
module pwm_shadow_ctrl
    import pwm_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 16,
    localparam int SEL_W    = $clog2(CHANNELS + 2)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               run,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [SEL_W-1:0]                   cfg_sel,
    input  logic [WIDTH-1:0]                   cfg_data,
    output logic                               cfg_err,
    output logic [WIDTH-1:0]                   counter_value,
    output logic [CHANNELS-1:0][WIDTH-1:0]     duty,
    output logic [CHANNELS-1:0]                enable,
    output logic                               period_tick,
    output logic                               update_pending,
    output logic                               busy
);

    localparam logic [SEL_W-1:0] SEL_PERIOD = SEL_W'(sel_period(CHANNELS));
    localparam logic [SEL_W-1:0] SEL_ENABLE = SEL_W'(sel_enable(CHANNELS));

    pwm_state_t state, state_next;

    logic                           wrap;
    logic                           count_en;
    logic                           load;
    logic                           accept;
    logic                           sel_valid;
    logic                           wr_ok;
    logic [WIDTH-1:0]               act_period;
    logic [WIDTH-1:0]               sh_period, sh_period_n;
    logic [CHANNELS-1:0][WIDTH-1:0] sh_duty, sh_duty_n;
    logic [CHANNELS-1:0]            sh_enable, sh_enable_n;

    assign count_en  = (state != IDLE);
    assign busy      = count_en;
    assign cfg_ready = !wrap;
    assign accept    = cfg_valid && cfg_ready;
    assign sel_valid = (cfg_sel <= SEL_ENABLE);
    assign wr_ok     = accept && sel_valid;
    assign load      = (state == IDLE) || wrap;

    pwm_timebase #(
        .WIDTH (WIDTH)
    ) u_timebase (
        .clk           (clk),
        .rst           (rst),
        .count_en      (count_en),
        .period        (act_period),
        .counter_value (counter_value),
        .period_tick   (wrap)
    );

    assign period_tick = wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = RUN;
            RUN:     if (!run) state_next = DRAIN;
            DRAIN: begin
                if (run) begin
                    state_next = RUN;
                end else if (wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next shadow contents; the load path reads these so an IDLE write shows up one cycle later.
    always_comb begin
        sh_period_n = sh_period;
        sh_duty_n   = sh_duty;
        sh_enable_n = sh_enable;
        if (wr_ok) begin
            if (cfg_sel == SEL_PERIOD) begin
                sh_period_n = cfg_data;
            end else if (cfg_sel == SEL_ENABLE) begin
                sh_enable_n = cfg_data[CHANNELS-1:0];
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (cfg_sel == SEL_W'(i)) begin
                        sh_duty_n[i] = cfg_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_period  <= '1;
            sh_duty    <= '0;
            sh_enable  <= '0;
            act_period <= '1;
            duty       <= '0;
            enable     <= '0;
        end else begin
            sh_period <= sh_period_n;
            sh_duty   <= sh_duty_n;
            sh_enable <= sh_enable_n;
            if (load) begin
                act_period <= sh_period_n;
                duty       <= sh_duty_n;
                enable     <= sh_enable_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_pending <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_err <= accept && !sel_valid;
            if (wr_ok) begin
                update_pending <= 1'b1;
            end else if (load) begin
                update_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_shadow_ctrl.sv
// tb/tb_pwm_shadow_ctrl.sv - self-checking bench for pwm_shadow_ctrl
module tb_pwm_shadow_ctrl;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int SW = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 run;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [SW-1:0]        cfg_sel;
    logic [W-1:0]         cfg_data;
    logic                 cfg_err;
    logic [W-1:0]         counter_value;
    logic [CH-1:0][W-1:0] duty;
    logic [CH-1:0]        enable;
    logic                 period_tick;
    logic                 update_pending;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_per, m_cnt, m_en, s_per, s_en;
    int m_duty[CH];
    int s_duty[CH];
    bit m_active, m_stopping, m_pend, m_err;

    pwm_shadow_ctrl #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_sel        (cfg_sel),
        .cfg_data       (cfg_data),
        .cfg_err        (cfg_err),
        .counter_value  (counter_value),
        .duty           (duty),
        .enable         (enable),
        .period_tick    (period_tick),
        .update_pending (update_pending),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int sel, input int data);
        bit done;
        done = 0;
        cfg_valid = 1'b1;
        cfg_sel   = SW'(sel);
        cfg_data  = W'(data);
        for (int i = 0; i < 20 && !done; i++) begin
            if (cfg_ready) done = 1;
            step();
        end
        cfg_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_timeout: sel %0d never accepted, ready=%0b expected 1", sel, cfg_ready);
        end
    endtask

    task automatic wait_counter(input int v);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (busy && counter_value == W'(v)) hit = 1;
            else step();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_counter: counter=%0d expected %0d", counter_value, v);
        end
    endtask

    task automatic wait_idle();
        bit hit;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (!busy) hit = 1;
            else step();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (counter_value !== '0 || duty !== '0 || enable !== '0 || cfg_ready !== 1'b1 ||
            cfg_err !== 1'b0 || period_tick !== 1'b0 || update_pending !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cnt=%0d duty=%h en=%h rdy=%0b err=%0b tick=%0b pend=%0b busy=%0b expected 0/0/0/1/0/0/0/0",
                     counter_value, duty, enable, cfg_ready, cfg_err, period_tick, update_pending, busy);
        end
        step();
    endtask

    task automatic test_basic_run();
        int highs;
        write(CH, 4);
        write(0, 2);
        write(CH + 1, 1);
        checks++;
        if (duty[0] !== 16'd2 || enable !== 4'h1 || update_pending !== 1'b1) begin
            errors++;
            $display("FAIL idle_load: duty0=%0d en=%h pend=%0b expected 2/1/1", duty[0], enable, update_pending);
        end
        run = 1'b1;
        step();
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (counter_value !== W'(i % 5) || period_tick !== (i % 5 == 4) || busy !== 1'b1) begin
                errors++;
                $display("FAIL count_seq: i=%0d cnt=%0d tick=%0b busy=%0b expected %0d/%0b/1",
                         i, counter_value, period_tick, busy, i % 5, (i % 5 == 4));
            end
            if (enable[0] && counter_value < duty[0]) highs++;
            step();
        end
        checks++;
        if (highs != 4) begin
            errors++;
            $display("FAIL pwm_duty: high cycles %0d expected 4", highs);
        end
    endtask

    task automatic test_midrun_update();
        wait_counter(1);
        cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_data = 16'd3;
        step();
        cfg_valid = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            checks++;
            if (counter_value !== W'(c) || duty[0] !== 16'd2 || update_pending !== 1'b1) begin
                errors++;
                $display("FAIL midrun_hold: cnt=%0d duty0=%0d pend=%0b expected %0d/2/1",
                         counter_value, duty[0], update_pending, c);
            end
            step();
        end
        checks++;
        if (counter_value !== '0 || duty[0] !== 16'd3 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL midrun_load: cnt=%0d duty0=%0d pend=%0b expected 0/3/0", counter_value, duty[0], update_pending);
        end
    endtask

    task automatic test_held_write();
        wait_counter(4);
        cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_data = 16'd1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ready: ready=%0b expected 0", cfg_ready);
        end
        step();
        checks++;
        if (cfg_ready !== 1'b1 || counter_value !== '0) begin
            errors++;
            $display("FAIL held_accept: ready=%0b cnt=%0d expected 1/0", cfg_ready, counter_value);
        end
        step();
        cfg_valid = 1'b0;
        wait_counter(4);
        checks++;
        if (duty[0] !== 16'd3 || update_pending !== 1'b1) begin
            errors++;
            $display("FAIL held_not_yet: duty0=%0d pend=%0b expected 3/1", duty[0], update_pending);
        end
        step();
        checks++;
        if (duty[0] !== 16'd1 || counter_value !== '0) begin
            errors++;
            $display("FAIL held_applied: duty0=%0d cnt=%0d expected 1/0", duty[0], counter_value);
        end
    endtask

    task automatic test_drain();
        wait_counter(2);
        run = 1'b0;
        step();
        for (int c = 3; c <= 4; c++) begin
            checks++;
            if (busy !== 1'b1 || counter_value !== W'(c)) begin
                errors++;
                $display("FAIL drain_count: busy=%0b cnt=%0d expected 1/%0d", busy, counter_value, c);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b0 || counter_value !== '0) begin
                errors++;
                $display("FAIL drain_idle: busy=%0b cnt=%0d expected 0/0", busy, counter_value);
            end
            step();
        end
        run = 1'b1;
        step();
        wait_counter(1);
        run = 1'b0;
        step();
        run = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            checks++;
            if (busy !== 1'b1 || counter_value !== W'(c % 5)) begin
                errors++;
                $display("FAIL drain_resume: busy=%0b cnt=%0d expected 1/%0d", busy, counter_value, c % 5);
            end
            step();
        end
        run = 1'b0;
        wait_idle();
    endtask

    task automatic test_period_zero_and_err();
        logic [CH-1:0][W-1:0] d0;
        logic [CH-1:0]        e0;
        write(CH, 0);
        run = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (counter_value !== '0 || period_tick !== 1'b1 || cfg_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL period_zero: cnt=%0d tick=%0b ready=%0b busy=%0b expected 0/1/0/1",
                         counter_value, period_tick, cfg_ready, busy);
            end
            step();
        end
        run = 1'b0;
        wait_idle();
        d0 = duty;
        e0 = enable;
        cfg_valid = 1'b1; cfg_sel = SW'(CH + 2); cfg_data = 16'hffff;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL bad_sel_pulse: err=%0b pend=%0b expected 1/0", cfg_err, update_pending);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0 || duty !== d0 || enable !== e0) begin
            errors++;
            $display("FAIL bad_sel_after: err=%0b duty=%h en=%h expected 0/%h/%h", cfg_err, duty, enable, d0, e0);
        end
        write(CH, 4);
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        step();
        wait_counter(3);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (counter_value !== '0 || duty !== '0 || enable !== '0 || busy !== 1'b0 ||
            period_tick !== 1'b0 || cfg_ready !== 1'b1 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d duty=%h en=%h busy=%0b tick=%0b rdy=%0b pend=%0b expected all reset",
                     counter_value, duty, enable, busy, period_tick, cfg_ready, update_pending);
        end
        run = 1'b0;
        step();
        rst = 1'b0;
        step();
        run = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (counter_value !== W'(i) || enable !== '0) begin
                errors++;
                $display("FAIL reset_period: cnt=%0d en=%h expected %0d/0", counter_value, enable, i);
            end
            step();
        end
        run = 1'b0;
    endtask

    task automatic test_random();
        bit v, wrap, acc, load, wr;
        int sel, data;
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b0;
        m_per = 16'hffff; s_per = 16'hffff; m_en = 0; s_en = 0; m_cnt = 0;
        m_active = 0; m_stopping = 0; m_pend = 0; m_err = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            s_duty[i] = 0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            if ($urandom_range(0, 15) == 0) run = !run;
            v    = ($urandom_range(0, 9) < 4);
            sel  = $urandom_range(0, 7);
            data = (sel == CH) ? $urandom_range(0, 6) : $urandom_range(0, 8);
            cfg_valid = v; cfg_sel = SW'(sel); cfg_data = W'(data);
            wrap = m_active && (m_cnt == m_per);
            checks++;
            if (counter_value !== W'(m_cnt) || period_tick !== wrap || cfg_ready !== !wrap || busy !== m_active) begin
                errors++;
                $display("FAIL rand_timebase: cyc=%0d cnt=%0d tick=%0b rdy=%0b busy=%0b expected %0d/%0b/%0b/%0b",
                         cyc, counter_value, period_tick, cfg_ready, busy, m_cnt, wrap, !wrap, m_active);
            end
            checks++;
            if (update_pending !== m_pend || cfg_err !== m_err || enable !== CH'(m_en)) begin
                errors++;
                $display("FAIL rand_status: cyc=%0d pend=%0b err=%0b en=%h expected %0b/%0b/%h",
                         cyc, update_pending, cfg_err, enable, m_pend, m_err, m_en);
            end
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (duty[c] !== W'(m_duty[c])) begin
                    errors++;
                    $display("FAIL rand_duty: cyc=%0d ch=%0d duty=%0d expected %0d", cyc, c, duty[c], m_duty[c]);
                end
            end
            acc   = v && !wrap;
            wr    = acc && (sel <= CH + 1);
            m_err = acc && (sel > CH + 1);
            if (wr) begin
                if (sel == CH) s_per = data;
                else if (sel == CH + 1) s_en = data & ((1 << CH) - 1);
                else s_duty[sel] = data;
            end
            load = !m_active || wrap;
            if (load) begin
                m_per = s_per;
                m_en  = s_en;
                for (int c = 0; c < CH; c++) m_duty[c] = s_duty[c];
            end
            if (wr) m_pend = 1;
            else if (load) m_pend = 0;
            m_cnt = load ? 0 : m_cnt + 1;
            if (!m_active) begin
                m_active   = run;
                m_stopping = 0;
            end else begin
                m_active   = !(wrap && m_stopping && !run);
                m_stopping = !run;
            end
            step();
        end
        cfg_valid = 1'b0;
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_midrun_update();
        test_held_write();
        test_drain();
        test_period_zero_and_err();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_shadow_ctrl.md
Name: pwm_shadow_ctrl

Overview:
Sequencer and configuration front-end for the multi-channel PWM comparator. It owns the PWM timebase counter and holds shadow copies of period, per-channel duty and per-channel enable. Shadow values transfer to the active set only at a period boundary, so glitch-free updates reach the comparator. It drives the comparator's counter_value, duty and enable inputs directly.

Parameters:
CHANNELS, 4, number of PWM channels
WIDTH, 16, counter/period/duty width
SEL_W, $clog2(CHANNELS+2), config select width (derived, not overridable)

Ports:
clk  in  1  single clock
rst  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = count, 0 = stop at end of current period
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid&&cfg_ready
cfg_sel  in  SEL_W  0..CHANNELS-1 = duty[sel]; CHANNELS = period; CHANNELS+1 = enable mask
cfg_data  in  WIDTH  write data; enable uses bits [CHANNELS-1:0]
cfg_err  out  1  one-cycle pulse: accepted write with sel > CHANNELS+1 (data dropped)
counter_value  out  WIDTH  timebase to comparator
duty  out  [CHANNELS-1:0][WIDTH-1:0]  active duty to comparator
enable  out  CHANNELS  active enable to comparator
period_tick  out  1  one-cycle pulse on wrap cycle
update_pending  out  1  shadow written since last load
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, synchronous release): state IDLE; counter_value 0; shadow and active duty 0; shadow and active period all-ones; enable 0; cfg_ready 1; cfg_err 0; period_tick 0; update_pending 0.
- Writes: an accepted write updates the addressed shadow register on that edge and sets update_pending. Writes never touch active registers directly.
- Load event: active <= shadow for period, duty, enable, all on one edge. Clears update_pending unless the same-cycle write is accepted (cannot occur in RUN, see cfg_ready).
- FSM states IDLE, RUN, DRAIN.
- IDLE: counter held 0; load event every cycle (a write is visible on outputs the cycle after acceptance); cfg_ready=1. run=1 -> RUN; the counter starts from 0 on the next cycle.
- RUN: counter increments by 1 per cycle. Wrap cycle = counter_value == active period. On the wrap edge, counter <= 0 and a load event occurs. period_tick=1 during the wrap cycle. run=0 -> DRAIN (counting continues).
- DRAIN: counts as RUN. On the wrap edge: load, counter <= 0, -> IDLE. run=1 again before the wrap -> RUN, with no disturbance to the count.
- cfg_ready = 0 only during a wrap cycle in RUN/DRAIN. This avoids a write/load race. A write held during a wrap cycle is accepted the next cycle and lands in the following period.
- Active period 0: every cycle is a wrap cycle. Counter stays 0, period_tick stays high, and cfg_ready is low continuously while RUN/DRAIN. Writes are possible only in IDLE.
- Duty > period: no clamping; the channel stays high all period. Duty 0 gives a constant low.
- The counter never exceeds the active period. A period shrunk in shadow takes effect only after the current wrap.
- Reset mid-operation: all state returns to reset values immediately. Pending shadow writes are lost.
- update_pending is registered. It is high from the cycle after an accepted write until the cycle after the load event.

Decomposition:
- Shared package pwm_pkg: sel encoding constants (SEL_PERIOD = CHANNELS, SEL_ENABLE = CHANNELS+1), FSM state typedef {IDLE, RUN, DRAIN}, reset constants.
- One natural sub-module: pwm_timebase (counter, wrap compare, period_tick). The controller instantiates it and the existing comparator sits downstream in the parent.

Test Plan:
1. Reset, write period=4, duty[0]=2, enable=0x1 in IDLE, run=1 -> counter sequence 0,1,2,3,4,0; period_tick on each counter=4 cycle; comparator pwm_out[0] high for 2 of every 5 cycles.
2. In RUN with counter=1, write duty[0]=3 -> duty[0] output stays 2 until the wrap edge, then 3; update_pending high from the cycle after the write until the cycle after the wrap.
3. Hold cfg_valid=1 with period=4 across a counter=4 cycle -> cfg_ready=0 that cycle; write accepted at counter=0; new value applied at the next wrap, not the current one.
4. Deassert run at counter=2 (period=4) -> busy stays 1 through counter=3,4; after the wrap state is IDLE, counter_value holds 0, busy=0; reassert run in DRAIN -> no break in the count.
5. Write period=0 in IDLE, run=1 -> counter_value constant 0, period_tick constant 1, cfg_ready 0; write sel=CHANNELS+2 in IDLE -> cfg_err pulses for one cycle and no register changes.
6. Assert rst asynchronously mid-period (counter=3) -> all outputs go to reset values without a clock edge; after release, IDLE with period all-ones, enable 0.
